imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory loader and fetch stage: LOAD fills memory word by word, RUN streams
// instructions to decode. Optional pc-overflow trap enabled by IMEM_FETCH_CTRL_TRAP_EN.
module imem_fetch_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              ld_overflow,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d;
  logic              if_valid_q, if_valid_d;
  logic [31:0]       if_instr_q, if_instr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              ld_overflow_q, ld_overflow_d;
  logic              in_load;
  logic              ld_fire;
  logic              fetch_adv;

  // Gating with reset keeps the loader from seeing a write window while reset is held.
  assign in_load   = (state_q == S_LOAD) && !reset;
  assign ld_fire   = ld_valid && in_load;
  assign fetch_adv = !if_valid_q || if_ready;

  assign ld_ready    = in_load;
  assign mem_we      = ld_fire;
  assign mem_wdata   = ld_data;
  assign mem_addr    = (state_q == S_LOAD) ? ld_cnt_q : pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign ld_overflow = ld_overflow_q;

`ifdef IMEM_FETCH_CTRL_TRAP_EN
  logic halted_q, halted_d;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ld_cnt_d      = ld_cnt_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    ld_overflow_d = ld_overflow_q;
`ifdef IMEM_FETCH_CTRL_TRAP_EN
    halted_d      = halted_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (ld_fire) begin
          ld_cnt_d = ld_cnt_q + ONE;
          if (ld_last) begin
            state_d = S_RUN;
            pc_d    = PC_INIT;
          end else if (ld_cnt_q == LAST_ADDR) begin
            ld_overflow_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (br_taken) begin
          // The redirect wins: drop the presented word and refetch from the target next edge.
          pc_d       = br_target;
          if_valid_d = 1'b0;
        end else if (fetch_adv) begin
          if_instr_d = mem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
`ifdef IMEM_FETCH_CTRL_TRAP_EN
          if (pc_q == LAST_ADDR) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + ONE;
          end
`else
          pc_d = pc_q + ONE;
`endif
        end
      end
      S_HALT: begin
        if_valid_d = 1'b0;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_LOAD;
      pc_q          <= '0;
      ld_cnt_q      <= '0;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      ld_overflow_q <= 1'b0;
`ifdef IMEM_FETCH_CTRL_TRAP_EN
      halted_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ld_cnt_q      <= ld_cnt_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      ld_overflow_q <= ld_overflow_d;
`ifdef IMEM_FETCH_CTRL_TRAP_EN
      halted_q      <= halted_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: stimulus queues expected memory writes and fetches,
// a negedge monitor (which also models the memory) pops and compares them.
module tb_imem_fetch_ctrl;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } txn_t;

  logic              clk;
  logic              reset;
  logic              ld_valid;
  logic              ld_ready;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              ld_overflow;
  logic              halted;

  logic [31:0]       mem     [DEPTH];
  logic [31:0]       exp_mem [DEPTH];
  txn_t              wr_q[$];
  txn_t              fe_q[$];
  int                checks;
  int                errors;
  logic [ADDR_W-1:0] ld_ptr;

  imem_fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .ld_overflow(ld_overflow),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor and memory model: acts on the falling edge, away from DUT updates.
  initial begin
    txn_t t;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hC0DE_0000 + i;
    forever begin
      @(negedge clk);
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", {27'b0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          t = wr_q.pop_front();
          $display("write addr=%0d data=%h", mem_addr, mem_wdata);
          check("wr_addr", {27'b0, mem_addr}, {27'b0, t.addr});
          check("wr_data", mem_wdata, t.data);
        end
        mem[mem_addr] = mem_wdata;
      end
      if (if_valid && if_ready) begin
        if (fe_q.size() == 0) begin
          check("unexpected_fetch", {27'b0, if_pc}, 32'hFFFF_FFFF);
        end else begin
          t = fe_q.pop_front();
          $display("fetch pc=%0d instr=%h", if_pc, if_instr);
          check("if_pc", {27'b0, if_pc}, {27'b0, t.addr});
          check("if_instr", if_instr, t.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] data, input logic last);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    wr_q.push_back('{addr: ld_ptr, data: data});
    exp_mem[ld_ptr] = data;
    ld_ptr = ld_ptr + 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic push_fetch(input logic [ADDR_W-1:0] pc);
    fe_q.push_back('{addr: pc, data: exp_mem[pc]});
  endtask

  task automatic run_fetch(input int budget);
    int n;
    n = 0;
    if_ready = 1'b1;
    while (fe_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if_ready = 1'b0;
    check("fetch_drain_timeout", fe_q.size(), 0);
  endtask

  task automatic wait_pc(input logic [ADDR_W-1:0] pc, input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(if_valid && if_pc == pc) && n < budget);
    check("wait_pc_reached", {27'b0, if_pc}, {27'b0, pc});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ld_ptr    = '0;
    ld_valid  = 1'b0;
    ld_data   = '0;
    ld_last   = 1'b0;
    if_ready  = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'hC0DE_0000 + i;

    // Reset with a loader request pending: no write window may open.
    reset    = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 32'hFFFF_0000;
    tick();
    tick();
    check("rst_ld_ready", {31'b0, ld_ready}, 0);
    check("rst_mem_we", {31'b0, mem_we}, 0);
    ld_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("post_rst_ld_ready", {31'b0, ld_ready}, 1);
    check("post_rst_if_valid", {31'b0, if_valid}, 0);
    check("post_rst_if_pc", {27'b0, if_pc}, 0);
    check("post_rst_if_instr", if_instr, 0);
    check("post_rst_overflow", {31'b0, ld_overflow}, 0);
    check("post_rst_halted", {31'b0, halted}, 0);

    // Five-word load ending in RUN with pc=0.
    for (int k = 0; k < 5; k++) load_word(32'h0BAD_0000 + k, k == 4);
    check("run_ld_ready", {31'b0, ld_ready}, 0);
    check("run_pc0", {27'b0, mem_addr}, 0);
    check("run_if_valid0", {31'b0, if_valid}, 0);

    // Stream, then stall at if_pc=2 for three cycles.
    for (int p = 0; p < 4; p++) push_fetch(ADDR_W'(p));
    if_ready = 1'b1;
    wait_pc(2, 10);
    if_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_if_valid", {31'b0, if_valid}, 1);
      check("stall_if_pc", {27'b0, if_pc}, 2);
      check("stall_if_instr", if_instr, exp_mem[2]);
      check("stall_pc", {27'b0, mem_addr}, 3);
    end
    if_ready = 1'b1;
    wait_pc(4, 10);

    // Redirect while word 4 is presented but not taken.
    br_taken  = 1'b1;
    br_target = 5'd20;
    if_ready  = 1'b0;
    tick();
    br_taken = 1'b0;
    check("br_if_valid", {31'b0, if_valid}, 0);
    check("br_pc", {27'b0, mem_addr}, 20);
    for (int p = 20; p < 23; p++) push_fetch(ADDR_W'(p));
    run_fetch(20);

    // Reset mid-fetch, then overflow load of 33 words followed by a full refill.
    reset    = 1'b1;
    ld_valid = 1'b1;
    #1;
    check("midrst_if_valid", {31'b0, if_valid}, 0);
    check("midrst_ld_ready", {31'b0, ld_ready}, 0);
    check("midrst_mem_we", {31'b0, mem_we}, 0);
    check("midrst_if_pc", {27'b0, if_pc}, 0);
    tick();
    ld_valid = 1'b0;
    reset    = 1'b0;
    ld_ptr   = '0;
    for (int k = 0; k < 31; k++) load_word(32'hA500_0000 + k, 1'b0);
    check("ovf_before_wrap", {31'b0, ld_overflow}, 0);
    for (int k = 31; k < 33; k++) load_word(32'hA500_0000 + k, 1'b0);
    check("ovf_after_wrap", {31'b0, ld_overflow}, 1);
    check("ovf_still_load", {31'b0, ld_ready}, 1);
    for (int k = 33; k < 64; k++) load_word(32'hA500_0000 + k, k == 63);
    check("refill_run", {31'b0, ld_ready}, 0);
    check("refill_pc0", {27'b0, mem_addr}, 0);

    // Fetch through the last word.
    for (int p = 0; p < DEPTH; p++) push_fetch(ADDR_W'(p));
`ifndef IMEM_FETCH_CTRL_TRAP_EN
    push_fetch('0);
`endif
    run_fetch(60);
`ifdef IMEM_FETCH_CTRL_TRAP_EN
    check("trap_halted", {31'b0, halted}, 1);
    check("trap_if_valid", {31'b0, if_valid}, 0);
    br_taken  = 1'b1;
    br_target = 5'd3;
    if_ready  = 1'b1;
    tick();
    br_taken = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("halt_if_valid", {31'b0, if_valid}, 0);
      check("halt_halted", {31'b0, halted}, 1);
      tick();
    end
    if_ready = 1'b0;
`else
    check("wrap_halted", {31'b0, halted}, 0);
    check("wrap_next_pc", {27'b0, if_pc}, 1);
    check("wrap_if_valid", {31'b0, if_valid}, 1);
`endif

    tick();
    check("wr_q_empty", wr_q.size(), 0);
    check("fe_q_empty", fe_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
